// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg: shared definitions for the multi-cycle MULTU/DIVU sequencer.
//   - ALU op codes of the shared 32-bit ALU (only ADDU/SUBU are issued here)
//   - sequencer state encoding and op-field bit positions
//   - iteration count and local two's-complement negators
package muldiv_seq_pkg;

    // One iteration per operand bit.
    localparam int ITER  = 32;
    localparam int CNT_W = $clog2(ITER);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ITER - 1);

    // op field: bit0 selects divide, bit1 requests signed operation
    localparam int OP_DIV_BIT = 0;
    localparam int OP_SGN_BIT = 1;

    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_OR   = 3'b001,
        ALU_ADDU = 3'b010,
        ALU_SUBU = 3'b110,
        ALU_SLT  = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v);
        return ~v + 64'd1;
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: request/grant bus between the sequencer and the shared ALU.
//   master (sequencer): drives alu_req, alu_op, alu_num1, alu_num2;
//                       receives alu_gnt and the combinational alu_result.
//   slave  (main FSM/ALU side): the mirror image.
interface muldiv_seq_if;
    import muldiv_seq_pkg::*;

    logic        alu_req;
    logic        alu_gnt;
    alu_op_e     alu_op;
    logic [31:0] alu_num1;
    logic [31:0] alu_num2;
    logic [31:0] alu_result;

    modport master (
        output alu_req, alu_op, alu_num1, alu_num2,
        input  alu_gnt, alu_result
    );

    modport slave (
        input  alu_req, alu_op, alu_num1, alu_num2,
        output alu_gnt, alu_result
    );

endinterface

// File: rtl/muldiv_seq_step.sv
// muldiv_seq_step: combinational datapath for one multiply/divide iteration.
//   is_div      : 1 = restoring divide step, 0 = shift-add multiply step
//   hi, lo      : current working register {hi,lo}
//   opnd        : multiplicand (multiply) or divisor (divide)
//   alu_result  : result of the shared ALU for the operands selected here
//   alu_op/num* : ALU operation and operands for this iteration
//   hi_nxt/lo_nxt : working register after this iteration commits
module muldiv_seq_step
    import muldiv_seq_pkg::*;
(
    input  logic        is_div,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    input  logic [31:0] opnd,
    input  logic [31:0] alu_result,
    output alu_op_e     alu_op,
    output logic [31:0] alu_num1,
    output logic [31:0] alu_num2,
    output logic [31:0] hi_nxt,
    output logic [31:0] lo_nxt
);

    logic [31:0] s;      // divide: remainder shifted left by one
    logic        t;      // divide: bit shifted out of the remainder
    logic        carry;  // multiply: carry out of hi + multiplicand

    assign s = {hi[30:0], lo[31]};
    assign t = hi[31];

    // Operand selection is kept apart from the next-state logic so the path
    // through the external ALU does not look like a loop inside one process.
    always_comb begin
        // NOTE: every output gets a default first, so no branch can leave a latch.
        alu_op   = ALU_ADDU;
        alu_num1 = hi;
        alu_num2 = opnd;
        if (is_div) begin
            alu_op   = ALU_SUBU;
            alu_num1 = s;
        end
    end

    always_comb begin
        // A wrapped 32-bit sum is smaller than either addend.
        carry  = (alu_result < hi);
        hi_nxt = hi;
        lo_nxt = lo;
        if (is_div) begin
            // t=1 means the true shifted remainder is >= 2^32 > divisor.
            if (t || (s >= opnd)) begin
                hi_nxt = alu_result;
                lo_nxt = {lo[30:0], 1'b1};
            end else begin
                hi_nxt = s;
                lo_nxt = {lo[30:0], 1'b0};
            end
        end else if (lo[0]) begin
            {hi_nxt, lo_nxt} = {carry, alu_result, lo[31:1]};
        end else begin
            {hi_nxt, lo_nxt} = {1'b0, hi, lo[31:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle MULTU/DIVU sequencer sharing the core's 32-bit ALU.
// Runs 32 shift-add multiply or restoring divide steps, one ALU op per
// granted cycle, and leaves the result in HI/LO.
//   clk, rst       : clock, synchronous active-high reset
//   start, op      : launch request (accepted in IDLE only), op[0]=divide,
//                    op[1]=signed (only with MULDIV_SIGNED_EN defined)
//   rs_val, rt_val : multiplicand/dividend, multiplier/divisor
//   busy, done     : not-IDLE indicator, one-cycle completion pulse
//   dbz            : divide-by-zero flag of the last operation
//   hi, lo         : result registers
//   alu            : req/gnt bus to the shared ALU (muldiv_seq_if.master)
// Optional feature macro: MULDIV_SIGNED_EN (signed MULT/DIV via local
// magnitude conversion at start and sign correction on entering FIN).
module muldiv_seq
    import muldiv_seq_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [31:0]         rs_val,
    input  logic [31:0]         rt_val,
    output logic                busy,
    output logic                done,
    output logic                dbz,
    output logic [31:0]         hi,
    output logic [31:0]         lo,
    muldiv_seq_if.master        alu
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
    logic               div_q, div_d, dbz_q, dbz_d;
    logic               neg_res_q, neg_res_d;   // quotient/product must be negated
    logic               neg_rem_q, neg_rem_d;   // remainder takes a negative sign

    logic               rs_neg, rt_neg;
    logic [31:0]        rs_mag, rt_mag;
    alu_op_e            step_op;
    logic [31:0]        step_num1, step_num2, hi_nxt, lo_nxt;
    logic [63:0]        fin_val;

`ifdef MULDIV_SIGNED_EN
    assign rs_neg = op[OP_SGN_BIT] & rs_val[31];
    assign rt_neg = op[OP_SGN_BIT] & rt_val[31];
`else
    logic unused_op_sgn;
    assign unused_op_sgn = op[OP_SGN_BIT];
    assign rs_neg = 1'b0;
    assign rt_neg = 1'b0;
`endif

    // Magnitudes come from a local negator; the ALU is not touched at start.
    assign rs_mag = rs_neg ? neg32(rs_val) : rs_val;
    assign rt_mag = rt_neg ? neg32(rt_val) : rt_val;

    muldiv_seq_step u_step (
        .is_div     (div_q),
        .hi         (hi_q),
        .lo         (lo_q),
        .opnd       (opnd_q),
        .alu_result (alu.alu_result),
        .alu_op     (step_op),
        .alu_num1   (step_num1),
        .alu_num2   (step_num2),
        .hi_nxt     (hi_nxt),
        .lo_nxt     (lo_nxt)
    );

    // Sign correction of the final iteration's result; a no-op when both
    // sign flags are clear (always the case for unsigned operations).
    always_comb begin
        fin_val = {hi_nxt, lo_nxt};
        if (div_q) begin
            fin_val[31:0]  = neg_res_q ? neg32(lo_nxt) : lo_nxt;
            fin_val[63:32] = neg_rem_q ? neg32(hi_nxt) : hi_nxt;
        end else if (neg_res_q) begin
            fin_val = neg64({hi_nxt, lo_nxt});
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        opnd_d    = opnd_q;
        div_d     = div_q;
        dbz_d     = dbz_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dbz_d     = 1'b0;
                    cnt_d     = CNT_LOAD;
                    div_d     = op[OP_DIV_BIT];
                    hi_d      = '0;
                    neg_res_d = rs_neg ^ rt_neg;
                    neg_rem_d = rs_neg;
                    if (op[OP_DIV_BIT] && (rt_val == '0)) begin
                        hi_d      = rs_val;
                        lo_d      = '1;
                        dbz_d     = 1'b1;
                        neg_res_d = 1'b0;
                        neg_rem_d = 1'b0;
                        state_d   = S_FIN;
                    end else begin
                        lo_d    = op[OP_DIV_BIT] ? rs_mag : rt_mag;
                        opnd_d  = op[OP_DIV_BIT] ? rt_mag : rs_mag;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                // Without a grant nothing moves, so a stalled step is replayed.
                if (alu.alu_gnt) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    {hi_d, lo_d} = {hi_nxt, lo_nxt};
                    if (cnt_q == '0) begin
                        {hi_d, lo_d} = fin_val;
                        state_d      = S_FIN;
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: datapath registers are reset too, not just the control state,
            // so HI/LO and the operand latches never expose X after reset.
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            opnd_q    <= '0;
            div_q     <= 1'b0;
            dbz_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            opnd_q    <= opnd_d;
            div_q     <= div_d;
            dbz_q     <= dbz_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_FIN);
    assign dbz  = dbz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    // The ALU bus is parked at ADDU 0,0 whenever the ALU is not requested.
    assign alu.alu_req  = (state_q == S_RUN);
    assign alu.alu_op   = alu.alu_req ? step_op   : ALU_ADDU;
    assign alu.alu_num1 = alu.alu_req ? step_num1 : '0;
    assign alu.alu_num2 = alu.alu_req ? step_num2 : '0;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed self-checking bench for muldiv_seq.
// Models the shared ALU (ADDU/SUBU) and the grant line; expected values are
// hand-computed constants.
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        busy, done, dbz;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;
    int lat, pulses;

    muldiv_seq_if alu_bus ();

    assign alu_bus.alu_result = (alu_bus.alu_op == ALU_SUBU) ?
                                (alu_bus.alu_num1 - alu_bus.alu_num2) :
                                (alu_bus.alu_num1 + alu_bus.alu_num2);

    muldiv_seq dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .done   (done),
        .dbz    (dbz),
        .hi     (hi),
        .lo     (lo),
        .alu    (alu_bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launch one operation and follow it to completion. Cycle k=1 is the
    // first cycle after the edge that samples start. Grant is dropped in
    // cycles drop_at..drop_at+drop_len-1; restart keeps start asserted with
    // different operands while busy. A few idle cycles follow done so that
    // any extra done pulse is counted.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int drop_at, input int drop_len, input bit restart,
                          output int lat_o, output int pulses_o);
        lat_o    = -1;
        pulses_o = 0;
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 120; k++) begin
            if (done) begin
                pulses_o++;
                if (lat_o < 0) lat_o = k;
            end
            alu_bus.alu_gnt = !((k >= drop_at) && (k < drop_at + drop_len));
            if (restart && busy) begin
                start  = 1'b1;
                op     = 2'b00;
                rs_val = 32'h0000_1234;
                rt_val = 32'h0000_5678;
            end else begin
                start = 1'b0;
            end
            if ((lat_o >= 0) && (k >= lat_o + 3)) break;
            @(posedge clk); #1;
        end
        start           = 1'b0;
        alu_bus.alu_gnt = 1'b1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
        alu_bus.alu_gnt = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state and parked ALU bus
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dbz",  64'(dbz),  64'd0);
        chk("rst_hilo", {hi, lo},  64'd0);
        chk("rst_req",  64'(alu_bus.alu_req), 64'd0);
        chk("rst_aluop", 64'(alu_bus.alu_op), 64'(ALU_ADDU));
        chk("rst_nums", {alu_bus.alu_num1, alu_bus.alu_num2}, 64'd0);

        // MULTU max*max, continuous grant: carry path, latency 33
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0, lat, pulses);
        chk("mulmax_lat",  64'(lat), 64'd33);
        chk("mulmax_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        chk("mulmax_busy", 64'(busy), 64'd0);

        // DIVU 100/7 with grant withheld 5 cycles mid-RUN
        run_op(2'b01, 32'd100, 32'd7, 5, 5, 1'b0, lat, pulses);
        chk("div100_lat", 64'(lat), 64'd38);
        chk("div100_lo",  64'(lo),  64'd14);
        chk("div100_hi",  64'(hi),  64'd2);
        chk("div100_dbz", 64'(dbz), 64'd0);

        // DIVU by zero, then MULTU 3*4 clears the flag
        run_op(2'b01, 32'd5, 32'd0, 0, 0, 1'b0, lat, pulses);
        chk("dbz_lat",  64'(lat), 64'd1);
        chk("dbz_hilo", {hi, lo}, 64'h0000_0005_FFFF_FFFF);
        chk("dbz_flag", 64'(dbz), 64'd1);
        run_op(2'b00, 32'd3, 32'd4, 0, 0, 1'b0, lat, pulses);
        chk("mul34_dbz",  64'(dbz), 64'd0);
        chk("mul34_hilo", {hi, lo}, 64'd12);

        // Divisor above 2^31 exercises the shifted-out remainder bit
        run_op(2'b01, 32'hFFFF_FFFE, 32'h8000_0001, 0, 0, 1'b0, lat, pulses);
        chk("divbig_lo", 64'(lo), 64'd1);
        chk("divbig_hi", 64'(hi), 64'h7FFF_FFFD);

        // Start held high through RUN and FIN is ignored
        run_op(2'b00, 32'h0001_0000, 32'h0001_0000, 0, 0, 1'b1, lat, pulses);
        chk("restart_pulses", 64'(pulses), 64'd1);
        chk("restart_lat",    64'(lat),    64'd33);
        chk("restart_hilo",   {hi, lo},    64'h0000_0001_0000_0000);
        chk("restart_idle",   64'(busy),   64'd0);

        // Reset in cycle T+10 of a multiply aborts it silently
        start = 1'b1; op = 2'b00; rs_val = 32'd100; rt_val = 32'd200;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("run_req",  64'(alu_bus.alu_req), 64'd1);
        chk("run_busy", 64'(busy), 64'd1);
        chk("run_num2", 64'(alu_bus.alu_num2), 64'd100);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hilo", {hi, lo},  64'd0);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) pulses++;
            @(posedge clk); #1;
        end
        chk("abort_nodone", 64'(pulses), 64'd0);
        run_op(2'b00, 32'd6, 32'd7, 0, 0, 1'b0, lat, pulses);
        chk("mul67_hilo", {hi, lo}, 64'd42);

`ifdef MULDIV_SIGNED_EN
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0, 0, 1'b0, lat, pulses);
        chk("sdiv_lo",  64'(lo),  64'hFFFF_FFFD);
        chk("sdiv_hi",  64'(hi),  64'hFFFF_FFFF);
        chk("sdiv_lat", 64'(lat), 64'd33);
        run_op(2'b10, 32'hFFFF_FFFD, 32'd5, 0, 0, 1'b0, lat, pulses);
        chk("smul_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
`else
        // op[1] has no effect: -7 is treated as 4294967289
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0, 0, 1'b0, lat, pulses);
        chk("usdiv_lo", 64'(lo), 64'h7FFF_FFFC);
        chk("usdiv_hi", 64'(hi), 64'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
